mar_access_ctrl: RTL and testbench
==================================

Name: mar_access_ctrl

Overview:
Sequencer and arbiter for the 13-bit memory address register and the memory port behind it.
Shares the MAR/memory path between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
Loads MAR, holds its output valid, strobes memory, waits a fixed latency and returns data with a one-cycle ack.
Sits between the control unit and the MAR/memory datapath.

Parameters:
ADDR_W, 13, address width; matches MAR width.
DATA_W, 16, memory data width.
MEM_LAT, 2, memory read/write latency in cycles after the strobe; legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request, level; held until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DATA_W  fetch data, valid with if_ack, held until next IF completion
ls_req  in  1  load/store request, level; held until ls_ack
ls_we  in  1  1 = store, 0 = load; stable while ls_req
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_ack  out  1  one-cycle load/store completion pulse
ls_rdata  out  DATA_W  load data, valid with ls_ack, held until next LS load completion
wr_MAR  out  1  MAR write strobe
re_MAR  out  1  MAR read/output enable
mar_din  out  ADDR_W  address into MAR
mem_rd  out  1  one-cycle memory read strobe
mem_wr  out  1  one-cycle memory write strobe
mem_wdata  out  DATA_W  store data to memory
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in every state except IDLE
grant_ls  out  1  0 = IF owns the path, 1 = LS; valid while busy

Behaviour:
- Reset: state IDLE; all strobes, acks and busy 0; mar_din, mem_wdata, if_rdata, ls_rdata 0; last_grant = LS, so IF wins the first tie.
- FSM: IDLE -> LOAD -> SELECT -> ACCESS -> WAIT -> RESP -> IDLE. All outputs are registered.
- IDLE: sample requests.
  - One request pending: grant it.
  - Both pending: grant the one not in last_grant (round-robin), then update last_grant.
  - Latch the granted address, write data and we into internal registers. The latched values are used for the rest of the transaction.
- LOAD (1 cycle): wr_MAR=1, mar_din = latched address.
- SELECT (1 cycle): re_MAR=1; MAR output becomes valid at the end of this cycle.
- ACCESS (1 cycle): re_MAR=1; mem_rd=1 for a load/fetch, or mem_wr=1 with mem_wdata = latched data for a store.
- WAIT (MEM_LAT cycles): re_MAR=1; 4-bit down-counter loaded with MEM_LAT-1 on entry. On the last WAIT cycle, capture mem_rdata into the granted requester's rdata register (loads/fetches only).
- RESP (1 cycle): re_MAR=0; pulse the granted requester's ack.
- re_MAR is held continuously high from SELECT through WAIT, because MAR drives high-Z when neither strobe is asserted. wr_MAR and re_MAR are never high together.
- Latency: request seen in IDLE at cycle 0 -> ack in cycle 4+MEM_LAT. The next grant is possible at cycle 5+MEM_LAT.
- Requesters must deassert req in the cycle after ack. Requests are not sampled in RESP.
- A store updates no rdata register.
- Request dropped mid-transaction: the transaction completes and ack still pulses; the requester ignores it.
- rst mid-transaction: next cycle is IDLE, all strobes 0, no ack issued, rdata registers cleared, last_grant = LS.

Decomposition:
- Shared package mar_ctrl_pkg:
  - state encoding constants ST_IDLE..ST_RESP (3-bit);
  - ADDR_W=13, DATA_W=16 defaults;
  - requester ID constants REQ_IF=0, REQ_LS=1.
- One sub-module, rr_arb2: two-input round-robin arbiter. Inputs: req[1:0], last_grant, clk, rst, update enable. Outputs: grant valid, grant ID.
- The FSM, latency counter and latch registers stay in mar_access_ctrl.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x0123, mem_rdata=0xBEEF in the last WAIT cycle -> wr_MAR with mar_din=0x0123 at cycle 1; re_MAR cycles 2-5; mem_rd at cycle 3; if_ack and if_rdata=0xBEEF at cycle 6.
- Store: ls_req=1, ls_we=1, ls_addr=0x1FFF, ls_wdata=0x55AA -> mem_wr one cycle with mem_wdata=0x55AA; mem_rd never asserted; ls_ack pulse; ls_rdata unchanged.
- Tie after reset: if_req and ls_req both high at cycle 0 -> IF served first (grant_ls=0); LS granted at cycle 7 and acked at cycle 13 (MEM_LAT=2).
- Fairness: both requesters re-request continuously for 4 transactions -> grants alternate IF, LS, IF, LS; no ack overlaps another.
- Reset mid-operation: assert rst during WAIT -> next cycle busy=0, re_MAR=0, no ack pulse; a new fetch afterwards completes normally.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15 -> ack at cycle 5 and cycle 19 respectively; wr_MAR and re_MAR never high simultaneously.

Source files
------------

// File: rtl/mar_ctrl_pkg.sv
// Shared definitions for the MAR/memory access sequencer.
package mar_ctrl_pkg;

  localparam int unsigned MAR_ADDR_W = 13;
  localparam int unsigned MAR_DATA_W = 16;

  // Width of the memory latency down-counter (MEM_LAT up to 15).
  localparam int unsigned CNT_W = 4;

  // Requester IDs, also used as the arbiter grant encoding.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SELECT = 3'd2,
    ST_ACCESS = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; remembers the last winner so a tie goes to the other side.
module rr_arb2
  import mar_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,       // [0] = IF, [1] = LS
  input  logic       upd_i,       // commit the current grant as last winner
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic last_grant_q, last_grant_d;

  // Grant decode and last-winner update.
  always_comb begin
    gnt_valid_o = |req_i;
    case (req_i)
      2'b01:   gnt_id_o = REQ_IF;
      2'b10:   gnt_id_o = REQ_LS;
      2'b11:   gnt_id_o = ~last_grant_q;
      default: gnt_id_o = REQ_IF;
    endcase
    last_grant_d = last_grant_q;
    if (upd_i && gnt_valid_o) begin
      last_grant_d = gnt_id_o;
    end
  end

  // Reset to LS so IF wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_LS;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mar_access_ctrl.sv
// Sequences MAR load/select and the memory strobe for two requesters (fetch and load/store).
module mar_access_ctrl
  import mar_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = MAR_ADDR_W,
  parameter int unsigned DATA_W  = MAR_DATA_W,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              wr_MAR,
  output logic              re_MAR,
  output logic [ADDR_W-1:0] mar_din,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_ls
);

  localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(MEM_LAT - 32'd1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              wr_mar_q, wr_mar_d;
  logic              re_mar_q, re_mar_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic              busy_q, busy_d;

  logic arb_valid, arb_id, arb_upd;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       ({ls_req, if_req}),
    .upd_i       (arb_upd),
    .gnt_valid_o (arb_valid),
    .gnt_id_o    (arb_id)
  );

  // Next state, transaction latches and registered-output next values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    arb_upd    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          arb_upd = 1'b1;
          gnt_d   = arb_id;
          if (arb_id == REQ_LS) begin
            addr_d  = ls_addr;
            we_d    = ls_we;
            wdata_d = ls_wdata;
          end else begin
            addr_d = if_addr;
            we_d   = 1'b0;
          end
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:   state_d = ST_SELECT;
      ST_SELECT: state_d = ST_ACCESS;
      ST_ACCESS: begin
        cnt_d   = WaitLoad;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          // Memory data is valid in the last wait cycle; stores leave rdata alone.
          if (!we_q) begin
            if (gnt_q == REQ_LS) begin
              ls_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    wr_mar_d = (state_d == ST_LOAD);
    // MAR floats when neither strobe is set, so keep re_MAR up through WAIT.
    re_mar_d = (state_d == ST_SELECT) || (state_d == ST_ACCESS) || (state_d == ST_WAIT);
    mem_rd_d = (state_d == ST_ACCESS) && !we_q;
    mem_wr_d = (state_d == ST_ACCESS) && we_q;
    if_ack_d = (state_d == ST_RESP) && (gnt_q == REQ_IF);
    ls_ack_d = (state_d == ST_RESP) && (gnt_q == REQ_LS);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_q      <= REQ_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      wr_mar_q   <= 1'b0;
      re_mar_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      wr_mar_q   <= wr_mar_d;
      re_mar_q   <= re_mar_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      if_ack_q   <= if_ack_d;
      ls_ack_q   <= ls_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_MAR    = wr_mar_q;
  assign re_MAR    = re_mar_q;
  assign mar_din   = addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_ack    = ls_ack_q;
  assign ls_rdata  = ls_rdata_q;
  assign busy      = busy_q;
  assign grant_ls  = gnt_q;

endmodule

// File: tb/tb_mar_access_ctrl.sv
// Self-checking bench: main instance at MEM_LAT=2 plus MEM_LAT=1 and MEM_LAT=15 instances.
module tb_mar_access_ctrl;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;

  typedef struct {
    bit            is_ls;
    bit            is_load;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            ack_cyc;
  } exp_t;

  exp_t exp_q[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [DW-1:0] mem_rdata;

  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            force_cyc = -1;
  logic [DW-1:0] force_val = '0;

  // Per-cycle memory data pattern, so a capture in the wrong cycle shows up as wrong data.
  function automatic logic [DW-1:0] pat(input int c);
    logic [31:0] cv;
    cv = c;
    return {4'hA, cv[11:0]};
  endfunction

  assign mem_rdata = (cyc == force_cyc) ? force_val : pat(cyc);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          ifack_a, lsack_a, wr_a, re_a, rd_a, mw_a, busy_a, gls_a;
  logic [DW-1:0] ifrd_a, lsrd_a, wd_a;
  logic [AW-1:0] md_a;
  logic          ifack_b, lsack_b, wr_b, re_b, rd_b, mw_b, busy_b, gls_b;
  logic [DW-1:0] ifrd_b, lsrd_b, wd_b;
  logic [AW-1:0] md_b;
  logic          ifack_c, lsack_c, wr_c, re_c, rd_c, mw_c, busy_c, gls_c;
  logic [DW-1:0] ifrd_c, lsrd_c, wd_c;
  logic [AW-1:0] md_c;

  mar_access_ctrl #(.MEM_LAT(2)) u_dut_a (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(ifack_a),
    .if_rdata(ifrd_a), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ack(lsack_a), .ls_rdata(lsrd_a), .wr_MAR(wr_a), .re_MAR(re_a),
    .mar_din(md_a), .mem_rd(rd_a), .mem_wr(mw_a), .mem_wdata(wd_a), .mem_rdata(mem_rdata),
    .busy(busy_a), .grant_ls(gls_a)
  );

  mar_access_ctrl #(.MEM_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(ifack_b),
    .if_rdata(ifrd_b), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ack(lsack_b), .ls_rdata(lsrd_b), .wr_MAR(wr_b), .re_MAR(re_b),
    .mar_din(md_b), .mem_rd(rd_b), .mem_wr(mw_b), .mem_wdata(wd_b), .mem_rdata(mem_rdata),
    .busy(busy_b), .grant_ls(gls_b)
  );

  mar_access_ctrl #(.MEM_LAT(15)) u_dut_c (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(ifack_c),
    .if_rdata(ifrd_c), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ack(lsack_c), .ls_rdata(lsrd_c), .wr_MAR(wr_c), .re_MAR(re_c),
    .mar_din(md_c), .mem_rd(rd_c), .mem_wr(mw_c), .mem_wdata(wd_c), .mem_rdata(mem_rdata),
    .busy(busy_c), .grant_ls(gls_c)
  );

  // Leaves the bench just after a clock edge with all instances in IDLE.
  task automatic apply_reset();
    rst = 1'b1;
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we = 1'b0;
    force_cyc = -1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b1;
    ls_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy_a, wr_a, re_a, rd_a, mw_a, ifack_a, lsack_a, gls_a} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl_a: got %b want 00000000",
               {busy_a, wr_a, re_a, rd_a, mw_a, ifack_a, lsack_a, gls_a});
    end
    n_cmp++;
    if ({md_a, wd_a, ifrd_a, lsrd_a} !== '0) begin
      n_err++;
      $display("FAIL reset_data_a: got mar_din=%h wdata=%h if_rdata=%h ls_rdata=%h want 0",
               md_a, wd_a, ifrd_a, lsrd_a);
    end
    n_cmp++;
    if ({busy_b, wr_b, re_b, ifack_b, lsack_b, busy_c, wr_c, re_c, ifack_c, lsack_c} !== '0)
    begin
      n_err++;
      $display("FAIL reset_ctrl_bc: got %b want 0",
               {busy_b, wr_b, re_b, ifack_b, lsack_b, busy_c, wr_c, re_c, ifack_c, lsack_c});
    end
    apply_reset();
  endtask

  task automatic test_single_fetch();
    int t0, rel;
    logic [6:0] exp_v, act_v;
    exp_t e;
    apply_reset();
    t0 = cyc;
    if_req = 1'b1;
    if_addr = 13'h0123;
    force_cyc = t0 + 5;
    force_val = 16'hBEEF;
    exp_q.push_back('{1'b0, 1'b1, 13'h0123, 16'hBEEF, t0 + 6});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rel = cyc - t0;
      exp_v = {rel == 1, rel >= 2 && rel <= 5, rel == 3, 1'b0, rel >= 1 && rel <= 6,
               rel == 6, 1'b0};
      act_v = {wr_a, re_a, rd_a, mw_a, busy_a, ifack_a, lsack_a};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL fetch_strobes rel=%0d: got %b want %b", rel, act_v, exp_v);
      end
      if (rel == 1) begin
        n_cmp++;
        if (md_a !== 13'h0123) begin
          n_err++;
          $display("FAIL fetch_mar_din: got %h want 0123", md_a);
        end
      end
      if (ifack_a || lsack_a) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL fetch_ack: got unexpected ack at rel=%0d want none", rel);
        end else begin
          e = exp_q.pop_front();
          if (lsack_a !== e.is_ls || cyc != e.ack_cyc || ifrd_a !== e.data) begin
            n_err++;
            $display("FAIL fetch_ack: got ls=%b cyc=%0d data=%h want ls=%b cyc=%0d data=%h",
                     lsack_a, cyc, ifrd_a, e.is_ls, e.ack_cyc, e.data);
          end
        end
      end
      @(posedge clk);
      #1;
      if (rel == 6) if_req = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL fetch_timeout: got %0d pending want 0", exp_q.size());
    end
    force_cyc = -1;
  endtask

  task automatic test_store();
    int t0, rel;
    logic [6:0] exp_v, act_v;
    exp_t e;
    apply_reset();
    t0 = cyc;
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_addr = 13'h1FFF;
    ls_wdata = 16'h55AA;
    exp_q.push_back('{1'b1, 1'b0, 13'h1FFF, 16'h0000, t0 + 6});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rel = cyc - t0;
      exp_v = {rel == 1, rel >= 2 && rel <= 5, 1'b0, rel == 3, rel >= 1 && rel <= 6,
               1'b0, rel == 6};
      act_v = {wr_a, re_a, rd_a, mw_a, busy_a, ifack_a, lsack_a};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL store_strobes rel=%0d: got %b want %b", rel, act_v, exp_v);
      end
      if (rel == 1 || rel == 3) begin
        n_cmp++;
        if (md_a !== 13'h1FFF || wd_a !== 16'h55AA) begin
          n_err++;
          $display("FAIL store_addr_data rel=%0d: got %h/%h want 1fff/55aa", rel, md_a, wd_a);
        end
      end
      if (ifack_a || lsack_a) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL store_ack: got unexpected ack at rel=%0d want none", rel);
        end else begin
          e = exp_q.pop_front();
          if (lsack_a !== e.is_ls || cyc != e.ack_cyc) begin
            n_err++;
            $display("FAIL store_ack: got ls=%b cyc=%0d want ls=%b cyc=%0d",
                     lsack_a, cyc, e.is_ls, e.ack_cyc);
          end
        end
      end
      @(posedge clk);
      #1;
      if (rel == 6) ls_req = 1'b0;
    end
    n_cmp++;
    if (lsrd_a !== 16'h0000 || ifrd_a !== 16'h0000 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL store_rdata: got ls=%h if=%h pending=%0d want 0/0/0",
               lsrd_a, ifrd_a, exp_q.size());
    end
    ls_we = 1'b0;
  endtask

  // Tie right after reset, then both requesters keep asking for two transactions each.
  task automatic test_tie_fairness();
    int t0, rel, if_left, ls_left;
    bit if_ackd, ls_ackd;
    exp_t e;
    apply_reset();
    t0 = cyc;
    if_left = 2;
    ls_left = 2;
    if_addr = 13'h0111;
    ls_addr = 13'h0222;
    ls_we = 1'b0;
    if_req = 1'b1;
    ls_req = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 13'h0111, pat(t0 + 5), t0 + 6});
    exp_q.push_back('{1'b1, 1'b1, 13'h0222, pat(t0 + 12), t0 + 13});
    exp_q.push_back('{1'b0, 1'b1, 13'h0111, pat(t0 + 19), t0 + 20});
    exp_q.push_back('{1'b1, 1'b1, 13'h0222, pat(t0 + 26), t0 + 27});
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      rel = cyc - t0;
      if_ackd = ifack_a;
      ls_ackd = lsack_a;
      n_cmp++;
      if ((wr_a && re_a) || (ifack_a && lsack_a)) begin
        n_err++;
        $display("FAIL tie_overlap rel=%0d: got wr/re=%b%b acks=%b%b want no overlap",
                 rel, wr_a, re_a, ifack_a, lsack_a);
      end
      if (busy_a && exp_q.size() != 0) begin
        n_cmp++;
        if (gls_a !== exp_q[0].is_ls || (wr_a && md_a !== exp_q[0].addr)) begin
          n_err++;
          $display("FAIL tie_grant rel=%0d: got grant_ls=%b mar_din=%h want %b %h",
                   rel, gls_a, md_a, exp_q[0].is_ls, exp_q[0].addr);
        end
      end
      if (ifack_a || lsack_a) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tie_ack: got unexpected ack at rel=%0d want none", rel);
        end else begin
          e = exp_q.pop_front();
          if (lsack_a !== e.is_ls || cyc != e.ack_cyc ||
              (e.is_ls ? lsrd_a : ifrd_a) !== e.data) begin
            n_err++;
            $display("FAIL tie_ack: got ls=%b cyc=%0d data=%h want ls=%b cyc=%0d data=%h",
                     lsack_a, cyc, e.is_ls ? lsrd_a : ifrd_a, e.is_ls, e.ack_cyc, e.data);
          end
        end
        if (ifack_a) if_left--;
        if (lsack_a) ls_left--;
      end
      @(posedge clk);
      #1;
      if_req = (if_left > 0) && !if_ackd;
      ls_req = (ls_left > 0) && !ls_ackd;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL tie_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  // After an IF-only transaction a later tie must go to LS.
  task automatic test_back_to_back();
    int t0, rel, if_left, ls_left;
    bit if_ackd, ls_ackd;
    exp_t e;
    apply_reset();
    t0 = cyc;
    if_left = 2;
    ls_left = 1;
    if_addr = 13'h0A0A;
    ls_addr = 13'h1505;
    if_req = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 13'h0A0A, pat(t0 + 5), t0 + 6});
    exp_q.push_back('{1'b1, 1'b1, 13'h1505, pat(t0 + 13), t0 + 14});
    exp_q.push_back('{1'b0, 1'b1, 13'h0A0A, pat(t0 + 20), t0 + 21});
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      rel = cyc - t0;
      if_ackd = ifack_a;
      ls_ackd = lsack_a;
      if (wr_a && exp_q.size() != 0) begin
        n_cmp++;
        if (md_a !== exp_q[0].addr || gls_a !== exp_q[0].is_ls) begin
          n_err++;
          $display("FAIL b2b_grant rel=%0d: got mar_din=%h grant_ls=%b want %h %b",
                   rel, md_a, gls_a, exp_q[0].addr, exp_q[0].is_ls);
        end
      end
      if (ifack_a || lsack_a) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_ack: got unexpected ack at rel=%0d want none", rel);
        end else begin
          e = exp_q.pop_front();
          if (lsack_a !== e.is_ls || ifack_a === e.is_ls || cyc != e.ack_cyc ||
              (e.is_ls ? lsrd_a : ifrd_a) !== e.data) begin
            n_err++;
            $display("FAIL b2b_ack: got ls=%b cyc=%0d data=%h want ls=%b cyc=%0d data=%h",
                     lsack_a, cyc, e.is_ls ? lsrd_a : ifrd_a, e.is_ls, e.ack_cyc, e.data);
          end
        end
        if (ifack_a) if_left--;
        if (lsack_a) ls_left--;
      end
      @(posedge clk);
      #1;
      if_req = (if_left > 0) && !if_ackd;
      ls_req = (rel + 1 >= 8) && (ls_left > 0) && !ls_ackd;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0, rel, acks;
    exp_t e;
    apply_reset();
    // Complete one fetch so if_rdata holds a non-zero value.
    t0 = cyc;
    if_addr = 13'h0042;
    if_req = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 13'h0042, pat(t0 + 5), t0 + 6});
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (ifrd_a !== e.data) begin
      n_err++;
      $display("FAIL rmid_first: got if_rdata=%h want %h", ifrd_a, e.data);
    end
    // Second fetch, reset while in WAIT.
    @(posedge clk);
    #1;
    t0 = cyc;
    if_addr = 13'h0155;
    if_req = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (re_a !== 1'b1 || busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_in_wait: got re=%b busy=%b want 1 1", re_a, busy_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy_a, re_a, wr_a, rd_a, mw_a, ifack_a, lsack_a} !== 7'b0 || ifrd_a !== '0) begin
      n_err++;
      $display("FAIL rmid_after: got ctrl=%b if_rdata=%h want 0000000 0000",
               {busy_a, re_a, wr_a, rd_a, mw_a, ifack_a, lsack_a}, ifrd_a);
    end
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ifack_a || lsack_a || busy_a) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL rmid_no_ack: got %0d active cycles want 0", acks);
    end
    // A fresh fetch completes normally.
    @(posedge clk);
    #1;
    t0 = cyc;
    if_addr = 13'h0777;
    if_req = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 13'h0777, pat(t0 + 5), t0 + 6});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (ifack_a || lsack_a) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rmid_new_ack: got unexpected ack at rel=%0d want none", rel);
        end else begin
          e = exp_q.pop_front();
          if (ifack_a !== 1'b1 || cyc != e.ack_cyc || ifrd_a !== e.data) begin
            n_err++;
            $display("FAIL rmid_new_ack: got if=%b cyc=%0d data=%h want 1 cyc=%0d data=%h",
                     ifack_a, cyc, ifrd_a, e.ack_cyc, e.data);
          end
        end
      end
      @(posedge clk);
      #1;
      if (rel == 6) if_req = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rmid_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  // One-cycle request pulse: all three latencies must still complete and ack.
  task automatic test_latency_sweep();
    int t0, ack_a, ack_b, ack_c, n_a, n_b, n_c, clash;
    logic [DW-1:0] d_a, d_b, d_c;
    apply_reset();
    t0 = cyc;
    if_addr = 13'h0AAA;
    if_req = 1'b1;
    @(posedge clk);
    #1;
    if_req = 1'b0;
    n_a = 0; n_b = 0; n_c = 0; clash = 0;
    ack_a = -1; ack_b = -1; ack_c = -1;
    d_a = '0; d_b = '0; d_c = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if ((wr_a && re_a) || (wr_b && re_b) || (wr_c && re_c)) clash++;
      if (ifack_a) begin n_a++; ack_a = cyc - t0; d_a = ifrd_a; end
      if (ifack_b) begin n_b++; ack_b = cyc - t0; d_b = ifrd_b; end
      if (ifack_c) begin n_c++; ack_c = cyc - t0; d_c = ifrd_c; end
    end
    n_cmp++;
    if (clash != 0) begin
      n_err++;
      $display("FAIL sweep_wr_re: got %0d overlapping cycles want 0", clash);
    end
    n_cmp++;
    if (n_b != 1 || ack_b != 5 || d_b !== pat(t0 + 4)) begin
      n_err++;
      $display("FAIL sweep_lat1: got n=%0d ack=%0d data=%h want 1 5 %h",
               n_b, ack_b, d_b, pat(t0 + 4));
    end
    n_cmp++;
    if (n_c != 1 || ack_c != 19 || d_c !== pat(t0 + 18)) begin
      n_err++;
      $display("FAIL sweep_lat15: got n=%0d ack=%0d data=%h want 1 19 %h",
               n_c, ack_c, d_c, pat(t0 + 18));
    end
    n_cmp++;
    if (n_a != 1 || ack_a != 6 || d_a !== pat(t0 + 5)) begin
      n_err++;
      $display("FAIL sweep_lat2_dropped: got n=%0d ack=%0d data=%h want 1 6 %h",
               n_a, ack_a, d_a, pat(t0 + 5));
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_tie_fairness();
    test_back_to_back();
    test_reset_mid();
    test_latency_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
